// File: rtl/peripheral_wb_burst_master_if.sv
// peripheral_wb_burst_master_if: command, write/read data streams and Wishbone B3 master bus
interface peripheral_wb_burst_master_if #(parameter int DW = 32, parameter int AW = 32, parameter int LW = 8);
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [AW-1:0] cmd_adr_i;
  logic          cmd_we_i;
  logic [1:0]    cmd_bte_i;
  logic [LW-1:0] cmd_len_i;
  logic          wdat_valid_i;
  logic          wdat_ready_o;
  logic [DW-1:0] wdat_i;
  logic [DW/8-1:0] wsel_i;
  logic          rdat_valid_o;
  logic [DW-1:0] rdat_o;
  logic          done_o;
  logic          err_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [2:0]    wb_cti_o;
  logic [1:0]    wb_bte_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i;
  logic          wb_err_i;
  modport master (
    input  cmd_valid_i, cmd_adr_i, cmd_we_i, cmd_bte_i, cmd_len_i, wdat_valid_i, wdat_i, wsel_i,
           wb_dat_i, wb_ack_i, wb_err_i,
    output cmd_ready_o, wdat_ready_o, rdat_valid_o, rdat_o, done_o, err_o,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o, wb_bte_o
  );
  modport slave (
    output cmd_valid_i, cmd_adr_i, cmd_we_i, cmd_bte_i, cmd_len_i, wdat_valid_i, wdat_i, wsel_i,
           wb_dat_i, wb_ack_i, wb_err_i,
    input  cmd_ready_o, wdat_ready_o, rdat_valid_o, rdat_o, done_o, err_o,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o, wb_bte_o
  );
endinterface

// File: rtl/peripheral_wb_burst_master.sv
// peripheral_wb_burst_master: Wishbone B3 burst master (linear/wrap) driven by a command + data stream
module peripheral_wb_burst_master #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int LW = 8
) (
  input logic wb_clk_i,
  input logic wb_rst_i,
  peripheral_wb_burst_master_if.master bus
);
  localparam int BW = DW / 8;
  typedef enum logic [1:0] {IDLE, LOAD, XFER} state_t;
  state_t r_state, w_next;
  logic r_we, r_single, r_done, r_err, r_rvalid;
  logic [1:0] r_bte;
  logic [LW-1:0] r_cnt;
  logic [AW-1:0] r_adr;
  logic [DW-1:0] r_dat, r_rdat;
  logic [BW-1:0] r_sel;
  logic w_accept, w_ack, w_err, w_last, w_load;
  logic [AW-1:0] w_mask, w_inc;
  assign w_accept = bus.cmd_valid_i && bus.cmd_ready_o;
  assign w_load   = r_state == LOAD && bus.wdat_valid_i;
  assign w_err    = r_state == XFER && bus.wb_err_i;
  assign w_ack    = r_state == XFER && bus.wb_ack_i && !bus.wb_err_i;
  assign w_last   = r_cnt == '0;
  // wrap-N keeps the address bits above the N-beat window fixed
  assign w_mask   = r_bte == 2'd0 ? '1 : (AW'(BW) << ({1'b0, r_bte} + 3'd1)) - AW'(1);
  assign w_inc    = r_adr + AW'(BW);
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && w_accept) w_next = bus.cmd_we_i ? LOAD : XFER;
    if (w_load) w_next = XFER;
    if (w_err || (w_ack && w_last)) w_next = IDLE;
    else if (w_ack) w_next = r_we ? LOAD : XFER;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_we     <= 1'b0;
      r_single <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_rvalid <= 1'b0;
      r_bte    <= '0;
      r_cnt    <= '0;
      r_adr    <= '0;
      r_dat    <= '0;
      r_rdat   <= '0;
      r_sel    <= '0;
    end else begin
      r_done   <= w_ack && w_last;
      r_err    <= w_err;
      r_rvalid <= w_ack && !r_we;
      if (w_ack && !r_we) r_rdat <= bus.wb_dat_i;
      if (w_accept) begin
        r_we     <= bus.cmd_we_i;
        r_single <= bus.cmd_len_i == '0;
        r_bte    <= bus.cmd_bte_i;
        r_cnt    <= bus.cmd_len_i;
        r_adr    <= bus.cmd_adr_i;
        if (!bus.cmd_we_i) r_sel <= '1;
      end
      if (w_load) begin
        r_dat <= bus.wdat_i;
        r_sel <= bus.wsel_i;
      end
      if (w_ack && !w_last) begin
        r_cnt <= r_cnt - LW'(1);
        r_adr <= (r_adr & ~w_mask) | (w_inc & w_mask);
      end
    end
  end
  // a completion pulse blocks acceptance for one cycle so commands never overlap it
  assign bus.cmd_ready_o  = r_state == IDLE && !r_done && !r_err;
  assign bus.wdat_ready_o = r_state == LOAD;
  assign bus.rdat_valid_o = r_rvalid;
  assign bus.rdat_o       = r_rdat;
  assign bus.done_o       = r_done;
  assign bus.err_o        = r_err;
  assign bus.wb_cyc_o     = r_state != IDLE;
  assign bus.wb_stb_o     = r_state == XFER;
  assign bus.wb_we_o      = r_we && r_state != IDLE;
  assign bus.wb_adr_o     = r_adr;
  assign bus.wb_dat_o     = r_dat;
  assign bus.wb_sel_o     = r_sel;
  assign bus.wb_cti_o     = (r_state == IDLE || r_single) ? 3'b000 : w_last ? 3'b111 : 3'b010;
  assign bus.wb_bte_o     = r_bte;
endmodule

// File: doc/peripheral_wb_burst_master.md
PERIPHERAL_WB_BURST_MASTER -- requirements
Module: peripheral_wb_burst_master

Interface
REQ-001 Parameter DW, default 32, data width; legal values 8/16/32/64.
REQ-002 Parameter AW, default 32, byte-address width.
REQ-003 Parameter LW, default 8, burst-length field width.
REQ-004 wb_clk_i  in  1  sole clock; all logic on rising edge.
REQ-005 wb_rst_i  in  1  synchronous, active-high reset.
REQ-006 cmd_valid_i  in  1  command request.
REQ-007 cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
REQ-008 cmd_adr_i  in  AW  start byte address, aligned to DW/8.
REQ-009 cmd_we_i  in  1  1=write burst, 0=read burst.
REQ-010 cmd_bte_i  in  2  burst type: 0 linear, 1 wrap-4, 2 wrap-8, 3 wrap-16.
REQ-011 cmd_len_i  in  LW  beats minus one; 0 = single classic cycle.
REQ-012 wdat_valid_i / wdat_ready_o  in/out  1  write-data handshake.
REQ-013 wdat_i  in  DW, wsel_i  in  DW/8  write data and byte selects.
REQ-014 rdat_valid_o  out  1, rdat_o  out  DW  read-data beat.
REQ-015 done_o  out  1  one-cycle pulse, burst completed without error.
REQ-016 err_o  out  1  one-cycle pulse, burst terminated by wb_err_i.
REQ-017 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone B3 control.
REQ-018 wb_adr_o  out  AW, wb_dat_o  out  DW, wb_sel_o  out  DW/8.
REQ-019 wb_cti_o  out  3, wb_bte_o  out  2  cycle-type and burst-type tags.
REQ-020 wb_dat_i  in  DW, wb_ack_i  in  1, wb_err_i  in  1  slave response.

Function
REQ-021 FSM states IDLE, LOAD, XFER; cmd_ready_o SHALL be 1 only in IDLE.
REQ-022 IDLE + cmd_valid_i: latch command; go LOAD if cmd_we_i=1, else XFER; wb_cyc_o=1 from next cycle.
REQ-023 LOAD: wdat_ready_o=1, wb_stb_o=0; on wdat_valid_i register wdat_i/wsel_i into wb_dat_o/wb_sel_o, go XFER.
REQ-024 XFER: wb_stb_o=1, outputs stable until wb_ack_i or wb_err_i sampled high.
REQ-025 wb_ack_i/wb_err_i with wb_stb_o=0 SHALL be ignored.
REQ-026 wb_cti_o: 000 when cmd_len_i=0; 010 on every beat but the last; 111 on the last beat of a multi-beat burst.
REQ-027 wb_bte_o = latched cmd_bte_i for the whole cycle; wb_sel_o all-ones on reads.
REQ-028 After each non-last ack: word index = adr>>log2(DW/8); linear adds 1 (wraps modulo 2^AW); wrap-N increments only the low log2(N) index bits.
REQ-029 Beat counter loads cmd_len_i, decrements per ack; last beat when counter=0.
REQ-030 Non-last write ack -> LOAD; non-last read ack -> XFER, next beat back-to-back (no idle cycle).
REQ-031 Read ack: rdat_o<=wb_dat_i and rdat_valid_o=1 for exactly the following cycle.
REQ-032 Last ack: wb_cyc_o, wb_stb_o drop next cycle, done_o pulses that same cycle, return IDLE.
REQ-033 wb_err_i: terminate immediately (cyc/stb low next cycle), err_o pulse, no done_o, no rdat_valid_o for that beat; err wins if ack and err coincide.
REQ-034 New command accepted no earlier than the cycle after done_o/err_o.

Reset
REQ-035 wb_rst_i high at an edge: state IDLE; wb_cyc_o, wb_stb_o, wb_we_o, rdat_valid_o, done_o, err_o, wdat_ready_o = 0; wb_adr_o, wb_dat_o, rdat_o = 0; wb_sel_o = 0; wb_cti_o=000; wb_bte_o=00; cmd_ready_o=1 after release.
REQ-036 Reset mid-burst SHALL abort with no done_o/err_o pulse; bus released next edge.

Verification
REQ-037 Single read adr 0x100 len 0, slave acks 1 cycle later -> cti 000, rdat_valid_o once with slave data, done_o one cycle after ack.
REQ-038 Read len 3 bte wrap-4 adr 0x0C, ack every cycle -> adr 0x0C,0x00,0x04,0x08; cti 010,010,010,111; four rdat_valid_o pulses.
REQ-039 Write len 2 linear adr 0x20, wdat_valid_i stalled 3 cycles before beat 2 -> stb low during stall, cyc high, adr 0x20,0x24,0x28, data order preserved.
REQ-040 Read len 7 linear, wb_err_i on beat 3 -> cyc low next cycle, err_o pulse, 2 rdat_valid_o pulses, no done_o.
REQ-041 Reset asserted during beat 2 of write len 3 -> all outputs at reset values next edge; following single read completes normally.
REQ-042 Linear read at adr 0xFFFFFFFC len 1 -> second adr 0x00000000, done_o pulses.
